// File: rtl/alu_req_arbiter_pkg.sv
// Shared types for alu_req_arbiter: FSM states, response flag layout and the req_op packing.
package alu_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // rsp_flags layout, MSB first: {cout, oflow, g, l, e, err}
  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic l;
    logic e;
    logic err;
  } flags_t;

  localparam int FLAGS_W   = $bits(flags_t);
  // req_op slot: {inp_valid[1:0], mode, cin, cmd, opa, opb}
  localparam int OP_CTRL_W = 4;

  function automatic int op_width(input int dw, input int cw);
    return 2 * dw + cw + OP_CTRL_W;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to slot 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one alu among NUM_REQ requesters with round-robin arbitration.
// Define ARB_PRIO0_EN to give requester 0 strict priority over the round-robin slots.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int NUM_REQ    = 4,
  parameter int ALU_LAT    = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  output logic [NUM_REQ-1:0]                                   req_ready,
  input  logic [NUM_REQ*op_width(DATA_WIDTH, CMD_WIDTH)-1:0]   req_op,
  output logic [NUM_REQ-1:0]                                   rsp_valid,
  output logic [2*DATA_WIDTH:0]                                rsp_res,
  output logic [5:0]                                           rsp_flags,
  output logic                                                 busy,
  output logic                                                 alu_ce,
  output logic                                                 alu_cin,
  output logic                                                 alu_mode,
  output logic [1:0]                                           alu_inp_valid,
  output logic [CMD_WIDTH-1:0]                                 alu_cmd,
  output logic [DATA_WIDTH-1:0]                                alu_opa,
  output logic [DATA_WIDTH-1:0]                                alu_opb,
  input  logic [2*DATA_WIDTH:0]                                alu_res,
  input  logic                                                 alu_cout,
  input  logic                                                 alu_oflow,
  input  logic                                                 alu_g,
  input  logic                                                 alu_l,
  input  logic                                                 alu_e,
  input  logic                                                 alu_err
);

  localparam int OP_W     = op_width(DATA_WIDTH, CMD_WIDTH);
  localparam int PW       = $clog2(NUM_REQ);
  localparam int CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int OPB_LSB  = 0;
  localparam int OPA_LSB  = DATA_WIDTH;
  localparam int CMD_LSB  = 2 * DATA_WIDTH;
  localparam int CIN_BIT  = CMD_LSB + CMD_WIDTH;
  localparam int MODE_BIT = CIN_BIT + 1;
  localparam int IV_LSB   = MODE_BIT + 1;

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] grant;
  logic               rr_any;
  logic               any;
  logic [OP_W-1:0]    sel_op;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      ptr_next;

  function automatic logic [PW-1:0] onehot_idx(input logic [NUM_REQ-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) idx = PW'(i);
    return idx;
  endfunction

`ifdef ARB_PRIO0_EN
  assign arb_req = req_valid & ~NUM_REQ'(1);
  assign grant   = req_valid[0] ? NUM_REQ'(1) : rr_grant;
  assign any     = req_valid[0] | rr_any;
`else
  assign arb_req = req_valid;
  assign grant   = rr_grant;
  assign any     = rr_any;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .any   (rr_any)
  );

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_op = req_op[i*OP_W +: OP_W];
  end

  assign grant_idx = onehot_idx(grant);
  assign ptr_next  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);

  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      wait_cnt      <= '0;
      grant_q       <= '0;
      rsp_valid     <= '0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
      alu_ce        <= 1'b0;
      alu_cin       <= 1'b0;
      alu_mode      <= 1'b0;
      alu_inp_valid <= '0;
      alu_cmd       <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
    end else begin
      unique case (state)
        // IDLE -> ISSUE: latch the winner's operation straight onto the alu ports
        ST_IDLE: begin
          if (any) begin
            grant_q       <= grant;
            alu_opb       <= sel_op[OPB_LSB +: DATA_WIDTH];
            alu_opa       <= sel_op[OPA_LSB +: DATA_WIDTH];
            alu_cmd       <= sel_op[CMD_LSB +: CMD_WIDTH];
            alu_cin       <= sel_op[CIN_BIT];
            alu_mode      <= sel_op[MODE_BIT];
            alu_inp_valid <= sel_op[IV_LSB +: 2];
            alu_ce        <= 1'b1;
            state         <= ST_ISSUE;
`ifdef ARB_PRIO0_EN
            if (!req_valid[0]) rr_ptr <= ptr_next;
`else
            rr_ptr <= ptr_next;
`endif
          end
        end
        // ISSUE -> WAIT: operands already stable, start the latency count
        ST_ISSUE: begin
          wait_cnt <= CNT_W'(ALU_LAT - 1);
          state    <= ST_WAIT;
        end
        // WAIT -> RESP: capture alu outputs unmodified
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_res   <= alu_res;
            rsp_flags <= flags_t'{cout: alu_cout, oflow: alu_oflow, g: alu_g,
                                  l: alu_l, e: alu_e, err: alu_err};
            rsp_valid <= grant_q;
            alu_ce    <= 1'b0;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        // RESP -> IDLE: single-cycle strobe
        ST_RESP: begin
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
